photonic_rx_engine: RTL and testbench



---
 rtl/photonic_rx_engine.sv | 274 +++++++++++++++++++++++++++
 tb/tb_photonic_rx_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/photonic_rx_engine.sv
//-----------------------------------------------------------------------------
// photonic_rx_engine
//
// Receive engine for a photonic interconnect node. A control packet announces
// a burst of `len` data packets; the engine replies ACK (space reserved in
// the receive FIFO) or NACK on the control transmit channel, then captures
// the announced data payloads into a show-ahead FIFO read by the processor.
// A run of TIMEOUT_CYC idle cycles during a burst aborts it.
//
// Optional feature macro: RX_STATS_EN
//   When defined, adds saturating statistics outputs stat_words,
//   stat_drops and stat_timeouts.
//
// Ports:
//   clk               clock
//   rst               synchronous active-high reset
//   node_id           this node's id
//   max_node          highest valid node id
//   control_rx_packet incoming control packet (all-zero = idle)
//   control_tx_packet registered ACK/NACK reply (all-zero = idle)
//   data_rx_packet    incoming data packet (all-zero = idle)
//   rd_en             pop request
//   rd_data           FIFO head payload (show-ahead)
//   rd_valid          FIFO non-empty
//   fifo_count        entries held
//   busy              burst reception in progress
//   xfer_done         one-cycle pulse: burst complete
//   xfer_error        one-cycle pulse: burst aborted by timeout
//   stat_words        (RX_STATS_EN) pushed words
//   stat_drops        (RX_STATS_EN) dropped data packets
//   stat_timeouts     (RX_STATS_EN) timeout aborts
//-----------------------------------------------------------------------------

// Checks that a push never lands on a full FIFO (reservation guarantees it).
module photonic_rx_engine_chk (
   input logic clk,
   input logic rst,
   input logic push,
   input logic full
);
   no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

module photonic_rx_engine #(
   parameter int NODE_W      = 16,
   parameter int PAYLOAD_W   = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NODE_W-1:0]               node_id,
   input  logic [NODE_W-1:0]               max_node,
   input  logic [NODE_W+PAYLOAD_W-1:0]     control_rx_packet,
   output logic [NODE_W+PAYLOAD_W-1:0]     control_tx_packet,
   input  logic [NODE_W+PAYLOAD_W-1:0]     data_rx_packet,
   input  logic                            rd_en,
   output logic [PAYLOAD_W-1:0]            rd_data,
   output logic                            rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            busy,
   output logic                            xfer_done,
`ifdef RX_STATS_EN
   output logic [31:0]                     stat_words,
   output logic [15:0]                     stat_drops,
   output logic [15:0]                     stat_timeouts,
`endif
   output logic                            xfer_error
);

   localparam int PKT_W  = NODE_W + PAYLOAD_W;
   localparam int LEN_W  = PAYLOAD_W - 2;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam int CMP_W  = (LEN_W > CNT_W) ? LEN_W : CNT_W;

   localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   // Reply word: node id, 2-bit code (10 = ACK, 01 = NACK), echoed length.
   function automatic logic [PKT_W-1:0] make_reply(input logic [NODE_W-1:0] id,
                                                   input logic [1:0]        code,
                                                   input logic [LEN_W-1:0]  len);
      return {id, code, len};
   endfunction

   state_t              state_r, state_nxt_s;
   logic [LEN_W-1:0]    rem_r, rem_nxt_s;
   logic [IDLE_W-1:0]   idle_r, idle_nxt_s;
   logic [PKT_W-1:0]    tx_r, tx_nxt_s;
   logic                done_r, done_nxt_s;
   logic                err_r, err_nxt_s;

   logic [PAYLOAD_W-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]     count_r;

   logic                 req_valid_s;
   logic [LEN_W-1:0]     len_s;
   logic [CNT_W-1:0]     free_s;
   logic                 len_fits_s;
   logic                 data_nonzero_s;
   logic                 data_mine_s;
   logic                 push_s;
   logic                 pop_s;

   // Request decode: addressed to us, our id in range, flag bits clear.
   assign len_s       = control_rx_packet[LEN_W-1:0];
   assign req_valid_s = (control_rx_packet != {PKT_W{1'b0}})
                     && (control_rx_packet[PKT_W-1:PAYLOAD_W] == node_id)
                     && (node_id != {NODE_W{1'b0}})
                     && (node_id <= max_node)
                     && (control_rx_packet[PAYLOAD_W-1:PAYLOAD_W-2] == 2'b00);

   // Free space is judged against the current occupancy only at ACK time.
   assign free_s     = CNT_FULL - count_r;
   assign len_fits_s = (len_s != {LEN_W{1'b0}}) && (CMP_W'(len_s) <= CMP_W'(free_s));

   assign data_nonzero_s = (data_rx_packet != {PKT_W{1'b0}});
   assign data_mine_s    = data_nonzero_s && (data_rx_packet[PKT_W-1:PAYLOAD_W] == node_id);
   assign pop_s          = rd_en && (count_r != {CNT_W{1'b0}});

   // Next-state, reply, counters and push decision for the burst FSM.
   always_comb begin
      state_nxt_s = state_r;
      rem_nxt_s   = rem_r;
      idle_nxt_s  = idle_r;
      tx_nxt_s    = {PKT_W{1'b0}};
      done_nxt_s  = 1'b0;
      err_nxt_s   = 1'b0;
      push_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid_s) begin
               if (len_fits_s) begin
                  tx_nxt_s    = make_reply(node_id, 2'b10, len_s);
                  state_nxt_s = ST_RECV;
                  rem_nxt_s   = len_s;
                  idle_nxt_s  = {IDLE_W{1'b0}};
               end else begin
                  tx_nxt_s    = make_reply(node_id, 2'b01, len_s);
               end
            end else begin
               tx_nxt_s = {PKT_W{1'b0}};
            end
         end
         ST_RECV: begin
            // A new request cannot be honoured mid-burst.
            if (req_valid_s) begin
               tx_nxt_s = make_reply(node_id, 2'b01, len_s);
            end else begin
               tx_nxt_s = {PKT_W{1'b0}};
            end
            if (data_mine_s) begin
               push_s     = 1'b1;
               rem_nxt_s  = rem_r - LEN_ONE;
               idle_nxt_s = {IDLE_W{1'b0}};
               if (rem_r == LEN_ONE) begin
                  state_nxt_s = ST_IDLE;
                  done_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_RECV;
               end
            end else begin
               // Zero packets and foreign packets both count as idle cycles.
               if (idle_r == IDLE_LAST) begin
                  state_nxt_s = ST_IDLE;
                  err_nxt_s   = 1'b1;
                  idle_nxt_s  = {IDLE_W{1'b0}};
               end else begin
                  idle_nxt_s  = idle_r + IDLE_ONE;
               end
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, burst counters and registered reply/pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         rem_r   <= {LEN_W{1'b0}};
         idle_r  <= {IDLE_W{1'b0}};
         tx_r    <= {PKT_W{1'b0}};
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         rem_r   <= rem_nxt_s;
         idle_r  <= idle_nxt_s;
         tx_r    <= tx_nxt_s;
         done_r  <= done_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   // FIFO storage; contents need no reset since rd_data is gated by rd_valid.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_rx_packet[PAYLOAD_W-1:0];
      end
   end

   // FIFO pointers (wrap naturally, depth is a power of two) and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef RX_STATS_EN
   // Saturating statistics; in IDLE no push happens, so drop = nonzero && !push.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_words    <= 32'd0;
         stat_drops    <= 16'd0;
         stat_timeouts <= 16'd0;
      end else begin
         if (push_s && (stat_words != 32'hFFFF_FFFF)) begin
            stat_words <= stat_words + 32'd1;
         end
         if (data_nonzero_s && !push_s && (stat_drops != 16'hFFFF)) begin
            stat_drops <= stat_drops + 16'd1;
         end
         if (err_nxt_s && (stat_timeouts != 16'hFFFF)) begin
            stat_timeouts <= stat_timeouts + 16'd1;
         end
      end
   end
`endif

   assign control_tx_packet = tx_r;
   assign xfer_done         = done_r;
   assign xfer_error        = err_r;
   assign busy              = (state_r == ST_RECV);
   assign fifo_count        = count_r;
   assign rd_valid          = (count_r != {CNT_W{1'b0}});
   assign rd_data           = rd_valid ? mem_r[rd_ptr_r] : {PAYLOAD_W{1'b0}};

   photonic_rx_engine_chk u_chk (
      .clk  (clk),
      .rst  (rst),
      .push (push_s),
      .full (count_r == CNT_FULL)
   );

endmodule

// File: tb/tb_photonic_rx_engine.sv
module tb_photonic_rx_engine;

   logic        clk;
   logic        rst;
   logic [15:0] node_id;
   logic [15:0] max_node;
   logic [31:0] control_rx_packet;
   logic [31:0] control_tx_packet;
   logic [31:0] data_rx_packet;
   logic        rd_en;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [3:0]  fifo_count;
   logic        busy;
   logic        xfer_done;
   logic        xfer_error;
`ifdef RX_STATS_EN
   logic [31:0] stat_words;
   logic [15:0] stat_drops;
   logic [15:0] stat_timeouts;
`endif

   int errors = 0;
   int checks = 0;

   photonic_rx_engine #(
      .NODE_W      (16),
      .PAYLOAD_W   (16),
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .node_id           (node_id),
      .max_node          (max_node),
      .control_rx_packet (control_rx_packet),
      .control_tx_packet (control_tx_packet),
      .data_rx_packet    (data_rx_packet),
      .rd_en             (rd_en),
      .rd_data           (rd_data),
      .rd_valid          (rd_valid),
      .fifo_count        (fifo_count),
      .busy              (busy),
      .xfer_done         (xfer_done),
`ifdef RX_STATS_EN
      .stat_words        (stat_words),
      .stat_drops        (stat_drops),
      .stat_timeouts     (stat_timeouts),
`endif
      .xfer_error        (xfer_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] burst1 [5];
      logic [15:0] drain  [5];
      burst1 = '{32'h0001_0005, 32'h0001_000A, 32'h0001_000B, 32'h0001_000C, 32'h0001_000D};

      rst               = 1'b1;
      node_id           = 16'h0001;
      max_node          = 16'h0004;
      control_rx_packet = 32'h0;
      data_rx_packet    = 32'h0;
      rd_en             = 1'b0;
      tick;
      tick;
      chk("reset_tx",    control_tx_packet, 32'h0);
      chk("reset_count", 32'(fifo_count), 32'h0);
      chk("reset_valid", 32'(rd_valid), 32'h0);
      chk("reset_busy",  32'(busy), 32'h0);
      chk("reset_done",  32'(xfer_done), 32'h0);
      chk("reset_err",   32'(xfer_error), 32'h0);
      rst = 1'b0;
      tick;

      // Basic 5-word burst.
      control_rx_packet = 32'h0001_0005;
      tick;
      chk("b1_ack",  control_tx_packet, 32'h0001_8005);
      chk("b1_busy", 32'(busy), 32'h1);
      control_rx_packet = 32'h0;
      for (int i = 0; i < 5; i++) begin
         data_rx_packet = burst1[i];
         tick;
         if (i == 0) chk("b1_tx_one_cycle", control_tx_packet, 32'h0);
         if (i == 3) chk("b1_no_early_done", 32'(xfer_done), 32'h0);
      end
      data_rx_packet = 32'h0;
      chk("b1_done",  32'(xfer_done), 32'h1);
      chk("b1_count", 32'(fifo_count), 32'h5);
      chk("b1_idle",  32'(busy), 32'h0);
      tick;
      chk("b1_done_pulse", 32'(xfer_done), 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("b1_read", 32'(rd_data), {16'h0, burst1[i][15:0]});
         rd_en = 1'b1;
         tick;
      end
      rd_en = 1'b0;
      chk("b1_empty", 32'(rd_valid), 32'h0);

      // Fill 6, then NACK for insufficient space, then ACK 2 to fill to 8.
      control_rx_packet = 32'h0001_0006;
      tick;
      chk("b2_ack", control_tx_packet, 32'h0001_8006);
      control_rx_packet = 32'h0;
      for (int i = 0; i < 6; i++) begin
         data_rx_packet = 32'h0001_0100 + 32'(i);
         tick;
      end
      data_rx_packet = 32'h0;
      chk("b2_count", 32'(fifo_count), 32'h6);
      control_rx_packet = 32'h0001_0003;
      tick;
      chk("nack_space", control_tx_packet, 32'h0001_4003);
      chk("nack_idle",  32'(busy), 32'h0);
      control_rx_packet = 32'h0001_0002;
      tick;
      chk("b3_ack",  control_tx_packet, 32'h0001_8002);
      chk("b3_busy", 32'(busy), 32'h1);
      control_rx_packet = 32'h0;
      data_rx_packet = 32'h0001_0200;
      tick;
      data_rx_packet = 32'h0001_0201;
      tick;
      data_rx_packet = 32'h0;
      chk("full_count", 32'(fifo_count), 32'h8);
      chk("b3_done",    32'(xfer_done), 32'h1);

      // Pop three, then stream a burst with rd_en held: count stays constant.
      for (int i = 0; i < 3; i++) begin
         chk("pop_pre", 32'(rd_data), 32'h0100 + 32'(i));
         rd_en = 1'b1;
         tick;
      end
      rd_en = 1'b0;
      chk("pop_count", 32'(fifo_count), 32'h5);
      control_rx_packet = 32'h0001_0003;
      tick;
      chk("b4_ack", control_tx_packet, 32'h0001_8003);
      control_rx_packet = 32'h0001_0001;
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("pp_head", 32'(rd_data), 32'h0103 + 32'(i));
         data_rx_packet = 32'h0001_0300 + 32'(i);
         tick;
         chk("pp_count", 32'(fifo_count), 32'h5);
         if (i == 0) begin
            chk("recv_nack",      control_tx_packet, 32'h0001_4001);
            chk("recv_nack_busy", 32'(busy), 32'h1);
            control_rx_packet = 32'h0;
         end
      end
      rd_en = 1'b0;
      data_rx_packet = 32'h0;
      chk("b4_done", 32'(xfer_done), 32'h1);
      drain = '{16'h0200, 16'h0201, 16'h0300, 16'h0301, 16'h0302};
      for (int i = 0; i < 5; i++) begin
         chk("b4_read", 32'(rd_data), 32'(drain[i]));
         rd_en = 1'b1;
         tick;
      end
      rd_en = 1'b0;
      chk("b4_empty", 32'(fifo_count), 32'h0);

      // Timeout: len 4, two words, then 16 idle cycles.
      control_rx_packet = 32'h0001_0004;
      tick;
      chk("to_ack", control_tx_packet, 32'h0001_8004);
      control_rx_packet = 32'h0;
      data_rx_packet = 32'h0001_0400;
      tick;
      data_rx_packet = 32'h0001_0401;
      tick;
      data_rx_packet = 32'h0;
      repeat (15) tick;
      chk("to_still_busy", 32'(busy), 32'h1);
      chk("to_no_err_yet", 32'(xfer_error), 32'h0);
      tick;
      chk("to_err",     32'(xfer_error), 32'h1);
      chk("to_idle",    32'(busy), 32'h0);
      chk("to_count",   32'(fifo_count), 32'h2);
      chk("to_no_done", 32'(xfer_done), 32'h0);
      tick;
      chk("to_err_pulse", 32'(xfer_error), 32'h0);
      for (int i = 0; i < 2; i++) begin
         chk("to_read", 32'(rd_data), 32'h0400 + 32'(i));
         rd_en = 1'b1;
         tick;
      end
      rd_en = 1'b0;

      // Ignored requests: wrong node, id above max_node, flags set; len 0 NACKs.
      control_rx_packet = 32'h0002_0005;
      tick;
      chk("ign_node_tx",   control_tx_packet, 32'h0);
      chk("ign_node_busy", 32'(busy), 32'h0);
      max_node = 16'h0000;
      control_rx_packet = 32'h0001_0005;
      tick;
      chk("ign_max_tx",   control_tx_packet, 32'h0);
      chk("ign_max_busy", 32'(busy), 32'h0);
      max_node = 16'h0004;
      control_rx_packet = 32'h0001_C005;
      tick;
      chk("ign_flag_tx", control_tx_packet, 32'h0);
      control_rx_packet = 32'h0001_0000;
      tick;
      chk("nack_len0", control_tx_packet, 32'h0001_4000);
      chk("len0_idle", 32'(busy), 32'h0);
      control_rx_packet = 32'h0;

      // Foreign data packet during a burst is dropped.
      control_rx_packet = 32'h0001_0003;
      tick;
      chk("dr_ack", control_tx_packet, 32'h0001_8003);
      control_rx_packet = 32'h0;
      data_rx_packet = 32'h0001_0501;
      tick;
      data_rx_packet = 32'h0003_0077;
      tick;
      data_rx_packet = 32'h0001_0502;
      tick;
      data_rx_packet = 32'h0001_0503;
      tick;
      data_rx_packet = 32'h0;
      chk("dr_done",  32'(xfer_done), 32'h1);
      chk("dr_count", 32'(fifo_count), 32'h3);
`ifdef RX_STATS_EN
      chk("st_drops",    32'(stat_drops), 32'h1);
      chk("st_words",    stat_words, 32'd21);
      chk("st_timeouts", 32'(stat_timeouts), 32'h1);
`endif
      drain = '{16'h0501, 16'h0502, 16'h0503, 16'h0000, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         chk("dr_read", 32'(rd_data), 32'(drain[i]));
         rd_en = 1'b1;
         tick;
      end
      rd_en = 1'b0;

      // Data in IDLE is dropped.
      data_rx_packet = 32'h0001_0099;
      tick;
      data_rx_packet = 32'h0;
      chk("idle_drop_count", 32'(fifo_count), 32'h0);
      chk("idle_drop_valid", 32'(rd_valid), 32'h0);
`ifdef RX_STATS_EN
      chk("st_drops_idle", 32'(stat_drops), 32'h2);
`endif

      // Reset mid-burst.
      control_rx_packet = 32'h0001_0004;
      tick;
      control_rx_packet = 32'h0;
      data_rx_packet = 32'h0001_0600;
      tick;
      data_rx_packet = 32'h0001_0601;
      tick;
      chk("mid_count", 32'(fifo_count), 32'h2);
      chk("mid_busy",  32'(busy), 32'h1);
      rst = 1'b1;
      control_rx_packet = 32'h0001_0001;
      data_rx_packet = 32'h0001_0602;
      tick;
      chk("rst_tx",    control_tx_packet, 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_count", 32'(fifo_count), 32'h0);
      chk("rst_valid", 32'(rd_valid), 32'h0);
      chk("rst_data",  32'(rd_data), 32'h0);
      chk("rst_done",  32'(xfer_done), 32'h0);
      chk("rst_err",   32'(xfer_error), 32'h0);
`ifdef RX_STATS_EN
      chk("rst_st_words", stat_words, 32'h0);
`endif
      rst = 1'b0;
      control_rx_packet = 32'h0;
      data_rx_packet = 32'h0;
      tick;
      chk("post_rst_done",  32'(xfer_done), 32'h0);
      chk("post_rst_err",   32'(xfer_error), 32'h0);
      chk("post_rst_count", 32'(fifo_count), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
